// File: rtl/gate2_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate2_checker
// Description : Exhaustive functional checker for a 2-input gate. On start it
//               drives the four input vectors (A=i[0], B=i[1], i=0..3) onto
//               the gate, holds each for SETTLE+1 cycles, samples the gate's
//               response Y at the last edge of each window and compares it to
//               TRUTH[i]. Reports the mismatch count, the per-vector fail mask
//               and an overall pass flag.
// Ports       : clk       - clock, rising edge active
//               rst       - asynchronous active-high reset
//               start     - begin a sweep (honoured only while idle)
//               A, B      - registered stimulus to the gate under test
//               Y         - response from the gate under test
//               busy      - sweep in progress
//               done      - one-cycle pulse at sweep completion
//               pass      - last completed sweep had no mismatches
//               err_count - mismatch count of current/last sweep (0..4)
//               fail_vec  - bit i set when vector i mismatched
// Revision    : 1.0 - initial release
// ============================================================================
module gate2_checker #(
    parameter int unsigned SETTLE = 2,        // legal 1..15
    parameter logic [3:0]  TRUTH  = 4'b1000   // expected Y per vector (AND2)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // Settle counter value at which the current vector's window closes.
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state, w_state;
    logic [1:0] r_idx,   w_idx;
    logic [3:0] r_cnt,   w_cnt;
    logic       r_a,     w_a;
    logic       r_b,     w_b;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic       r_pass,  w_pass;
    logic [2:0] r_err,   w_err;
    logic [3:0] r_fail,  w_fail;

    logic       w_mismatch;
    logic [2:0] w_err_inc;
    logic [1:0] w_idx_next;

    assign w_mismatch = (Y != TRUTH[r_idx]);
    // Four vectors bound the count at 4; the guard keeps it from ever wrapping.
    assign w_err_inc  = (r_err == 3'd4) ? r_err : (r_err + 3'd1);
    assign w_idx_next = r_idx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_fail  <= w_fail;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_err   = r_err;
        w_fail  = r_fail;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_RUN;
                    w_idx   = 2'd0;
                    w_cnt   = 4'd0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b1;
                    w_pass  = 1'b0;
                    w_err   = 3'd0;
                    w_fail  = 4'd0;
                end
            end

            S_RUN: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    // Last edge of the window: score this vector.
                    if (w_mismatch) begin
                        w_err         = w_err_inc;
                        w_fail[r_idx] = 1'b1;
                    end
                    if (r_idx == 2'd3) begin
                        // Pass decision includes the final vector's result.
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err == 3'd0);
                    end else begin
                        // Next vector goes out on the same edge, no gap cycle.
                        w_idx = w_idx_next;
                        w_a   = w_idx_next[0];
                        w_b   = w_idx_next[1];
                        w_cnt = 4'd0;
                    end
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end

            S_DONE: begin
                // start is not honoured here; a held start is seen in IDLE.
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign A         = r_a;
    assign B         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate2_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate2_checker
// Description : Directed self-checking bench for gate2_checker. One instance
//               (defaults, SETTLE=2, AND2 truth) checks a bench-side gate that
//               can be AND2, tied 0 or tied 1; two SETTLE=1 instances check an
//               XOR gate against matching and fully inverted truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate2_checker;

    logic clk = 1'b0;
    logic rst;
    logic start0;
    logic start_x;
    int   y_mode;            // 0 = AND2, 1 = tied 0, 2 = tied 1

    logic       a0, b0, y0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;

    logic       ax, bx, yx, busyx, donex, passx;
    logic [2:0] errx;
    logic [3:0] failx;

    logic       an, bn, yn, busyn, donen, passn;
    logic [2:0] errn;
    logic [3:0] failn;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign y0 = (y_mode == 0) ? (a0 & b0) : (y_mode == 2);
    assign yx = ax ^ bx;
    assign yn = an ^ bn;

    gate2_checker dut (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .Y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    gate2_checker #(.SETTLE(1), .TRUTH(4'b0110)) dut_x (
        .clk(clk), .rst(rst), .start(start_x), .A(ax), .B(bx), .Y(yx),
        .busy(busyx), .done(donex), .pass(passx), .err_count(errx), .fail_vec(failx)
    );

    gate2_checker #(.SETTLE(1), .TRUTH(4'b1001)) dut_xn (
        .clk(clk), .rst(rst), .start(start_x), .A(an), .B(bn), .Y(yn),
        .busy(busyn), .done(donen), .pass(passn), .err_count(errn), .fail_vec(failn)
    );

    // Reset asserted before any clock edge must clear outputs immediately.
    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start_x = 1'b0; y_mode = 0;
        #2;
        n_cmp++; if ({a0, b0, busy0, done0, pass0} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {a0, b0, busy0, done0, pass0}); end
        n_cmp++; if (err0 !== 3'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err0); end
        n_cmp++; if (fail0 !== 4'b0000) begin n_fail++; $display("FAIL reset_fail got %b want 0000", fail0); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        n_cmp++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL reset_release got %b want 00", {busy0, done0}); end
    endtask

    // Full SETTLE=2 sweep on the default instance; e_* are the hand-derived
    // final results. Running err/fail follow from e_fail: vector j is scored
    // at edge 3*(j+1).
    task automatic run_sweep0(input int mode, input logic [2:0] e_err, input logic [3:0] e_fail,
                              input logic e_pass, input logic repulse, input string tag);
        int         v;
        logic [3:0] run_fail;
        logic [2:0] run_err;
        y_mode = mode;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        n_cmp++; if ({busy0, done0, a0, b0} !== 4'b1000) begin n_fail++; $display("FAIL %s start_flags got %b want 1000", tag, {busy0, done0, a0, b0}); end
        n_cmp++; if ({err0, fail0, pass0} !== 8'b0) begin n_fail++; $display("FAIL %s start_clear got %b want 00000000", tag, {err0, fail0, pass0}); end
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1; start0 = 1'b0;
            v = (k >= 12) ? 3 : k / 3;
            run_fail = 4'b0000; run_err = 3'd0;
            for (int j = 0; j < 4; j++) begin
                if ((3 * (j + 1) <= k) && e_fail[j]) begin run_fail[j] = 1'b1; run_err++; end
            end
            n_cmp++; if ({a0, b0} !== {v[0], v[1]}) begin n_fail++; $display("FAIL %s ab edge %0d got %b want %b", tag, k, {a0, b0}, {v[0], v[1]}); end
            n_cmp++; if (busy0 !== (k < 12)) begin n_fail++; $display("FAIL %s busy edge %0d got %b want %b", tag, k, busy0, (k < 12)); end
            n_cmp++; if (done0 !== (k == 12)) begin n_fail++; $display("FAIL %s done edge %0d got %b want %b", tag, k, done0, (k == 12)); end
            n_cmp++; if (fail0 !== run_fail) begin n_fail++; $display("FAIL %s fail_vec edge %0d got %b want %b", tag, k, fail0, run_fail); end
            n_cmp++; if (err0 !== run_err) begin n_fail++; $display("FAIL %s err_count edge %0d got %0d want %0d", tag, k, err0, run_err); end
            if (k >= 12) begin
                n_cmp++; if (pass0 !== e_pass) begin n_fail++; $display("FAIL %s pass edge %0d got %b want %b", tag, k, pass0, e_pass); end
            end
            if (repulse && (k == 2 || k == 6)) start0 = 1'b1;
        end
        n_cmp++; if (err0 !== e_err) begin n_fail++; $display("FAIL %s final_err got %0d want %0d", tag, err0, e_err); end
    endtask

    // start held high: sweep ends at edge 12, idle at 13, restart at 14.
    task automatic test_hold_start();
        y_mode = 0;
        @(negedge clk); start0 = 1'b1;
        for (int k = 0; k <= 27; k++) begin
            @(posedge clk); #1;
            if (k == 12) begin
                n_cmp++; if ({done0, busy0} !== 2'b10) begin n_fail++; $display("FAIL hold done12 got %b want 10", {done0, busy0}); end
            end
            if (k == 13) begin
                n_cmp++; if ({done0, busy0, a0, b0} !== 4'b0011) begin n_fail++; $display("FAIL hold idle13 got %b want 0011", {done0, busy0, a0, b0}); end
            end
            if (k == 14) begin
                n_cmp++; if ({done0, busy0, a0, b0} !== 4'b0100) begin n_fail++; $display("FAIL hold restart14 got %b want 0100", {done0, busy0, a0, b0}); end
                start0 = 1'b0;
            end
            if (k == 26) begin
                n_cmp++; if ({done0, pass0, err0} !== 5'b11000) begin n_fail++; $display("FAIL hold done26 got %b want 11000", {done0, pass0, err0}); end
            end
            if (k == 27) begin
                n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL hold done27 got %b want 0", done0); end
            end
        end
    endtask

    // XOR gate, SETTLE=1: matching table passes, inverted table fails all four.
    task automatic test_xor();
        int v;
        @(negedge clk); start_x = 1'b1;
        @(posedge clk); #1; start_x = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            v = (k >= 8) ? 3 : k / 2;
            n_cmp++; if ({ax, bx} !== {v[0], v[1]}) begin n_fail++; $display("FAIL xor ab edge %0d got %b want %b", k, {ax, bx}, {v[0], v[1]}); end
            n_cmp++; if ({donex, donen} !== {2{k == 8}}) begin n_fail++; $display("FAIL xor done edge %0d got %b want %b", k, {donex, donen}, {2{k == 8}}); end
            if (k == 8) begin
                n_cmp++; if ({passx, errx, failx} !== 8'b1_000_0000) begin n_fail++; $display("FAIL xor_match result got %b want 10000000", {passx, errx, failx}); end
                n_cmp++; if ({passn, errn, failn} !== 8'b0_100_1111) begin n_fail++; $display("FAIL xor_inv result got %b want 01001111", {passn, errn, failn}); end
            end
        end
    endtask

    // Reset a couple of ns after edge 5 of a tied-1 sweep: outputs clear
    // before the next edge and no done pulse follows.
    task automatic test_reset_mid();
        y_mode = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        n_cmp++; if ({a0, b0, busy0, done0, pass0} !== 5'b0) begin n_fail++; $display("FAIL rst_mid flags got %b want 00000", {a0, b0, busy0, done0, pass0}); end
        n_cmp++; if ({err0, fail0} !== 7'b0) begin n_fail++; $display("FAIL rst_mid counts got %b want 0000000", {err0, fail0}); end
        @(posedge clk); @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            n_cmp++; if ({done0, busy0} !== 2'b00) begin n_fail++; $display("FAIL rst_mid quiet cycle %0d got %b want 00", k, {done0, busy0}); end
        end
        run_sweep0(0, 3'd0, 4'b0000, 1'b1, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        run_sweep0(0, 3'd0, 4'b0000, 1'b1, 1'b0, "and2");
        run_sweep0(1, 3'd1, 4'b1000, 1'b0, 1'b0, "tie0");
        run_sweep0(2, 3'd3, 4'b0111, 1'b0, 1'b0, "tie1");
        run_sweep0(0, 3'd0, 4'b0000, 1'b1, 1'b0, "and2_again");
        run_sweep0(1, 3'd1, 4'b1000, 1'b0, 1'b1, "repulse");
        test_hold_start();
        test_xor();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate2_checker.md
GATE2_CHECKER -- requirements
Module: gate2_checker

Interface
REQ-001 Parameter SETTLE, default 2: cycles each input vector is held before Y is sampled (legal 1..15).
REQ-002 Parameter TRUTH, default 4'b1000: expected Y for vector i at bit TRUTH[i] (4'b1000 = AND2).
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin an exhaustive sweep; sampled on rising clk.
REQ-006 A  output  1  stimulus to the 2-input gate under test (registered).
REQ-007 B  output  1  stimulus to the 2-input gate under test (registered).
REQ-008 Y  input  1  response from the gate under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 err_count  output  3  mismatch count of the current or last sweep, range 0..4.
REQ-013 fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge SHALL enter RUN at that edge, load vector index i=0, drive A=0 and B=0, set busy=1, clear err_count and fail_vec, and clear pass.
REQ-016 Vector encoding SHALL be A=i[0], B=i[1]; sweep order i = 0,1,2,3.
REQ-017 Each vector SHALL be held on A/B for exactly SETTLE+1 cycles, with a settle counter reloaded on each new vector.
REQ-018 Y SHALL be sampled at the last edge of each vector window; a mismatch (Y != TRUTH[i]) SHALL increment err_count and set fail_vec[i] at that edge.
REQ-019 At the sampling edge for i<3, the block SHALL advance i and update A/B to the next vector on the same edge, with no gap cycle.
REQ-020 At the sampling edge for i=3, the block SHALL enter DONE, set busy=0, set done=1, and set pass=1 iff the final err_count is 0, with the i=3 mismatch included.
REQ-021 DONE SHALL last one cycle, then return to IDLE with done=0; A/B SHALL hold the last vector until the next start.
REQ-022 The first done SHALL occur 4*(SETTLE+1) edges after the start edge.
REQ-023 start SHALL be ignored in RUN and DONE; a start held high continuously SHALL restart the sweep from IDLE on the cycle after DONE.
REQ-024 err_count SHALL saturate at 4, which is reachable only by four mismatches; it SHALL never wrap.
REQ-025 pass, err_count and fail_vec SHALL hold their values in IDLE until the next start.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, i=0 and settle counter=0, independent of clk.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; a start after rst deasserts SHALL run a complete fresh sweep.

Verification
REQ-028 AND2 gate under test, SETTLE=2, start pulsed at edge 0 -> busy=1 from edge 0; A/B step 00,10,01,11 (A,B) every 3 cycles; done at edge 12; pass=1, err_count=0, fail_vec=0000.
REQ-029 Y tied 0, TRUTH=4'b1000 -> done at edge 12; err_count=1, fail_vec=1000, pass=0.
REQ-030 Y tied 1 -> err_count=3, fail_vec=0111, pass=0; then Y wired to AND2 and a second start -> err_count=0, fail_vec=0000, pass=1.
REQ-031 XOR gate under test, TRUTH=4'b0110, SETTLE=1 -> done at edge 8, pass=1; same run with TRUTH=4'b1001 -> err_count=4, fail_vec=1111.
REQ-032 start re-pulsed at edges 3 and 7 during a sweep -> no effect, done still at edge 12; rst pulsed at edge 5 of a new sweep -> all outputs 0 immediately, no done pulse, and the next start completes normally.
